// File: rtl/puf_crp_controller.sv
// Clocked challenge/response initiator for an asynchronous arbiter PUF.
// Define PUF_MAJORITY_VOTE_EN to run VOTES queries per request and return the per-bit majority.
module puf_crp_controller #(
   parameter int C_BITS        = 4,
   parameter int R_BITS        = 4,
   parameter int RST_CYCLES    = 2,
   parameter int SETTLE_CYCLES = 8,
   parameter int VOTES         = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [C_BITS-1:0] req_challenge,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [R_BITS-1:0] rsp_data,
   output logic              rsp_stable,
   output logic              busy,
   output logic              puf_reset,
   output logic              puf_enable,
   output logic [C_BITS-1:0] puf_challenge,
   input  logic [R_BITS-1:0] puf_resp,
   output logic [2:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid and its payload stay stable until that edge, ready never waits on valid.
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRST = 3'd1;
   localparam logic [2:0] S_GAP  = 3'd2;
   localparam logic [2:0] S_FIRE = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   if (RST_CYCLES < 1 || SETTLE_CYCLES < 3 || VOTES < 3 || (VOTES % 2) == 0) begin : g_bad_params
      $error("puf_crp_controller: illegal parameter combination");
   end

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [C_BITS-1:0] chal_q, chal_d;
   logic [R_BITS-1:0] data_q, data_d;
   logic              stable_q, stable_d;
   logic [R_BITS-1:0] sync1_q, sync2_q;
   logic              req_ready_q, rsp_valid_q, busy_q, puf_reset_q, puf_enable_q;

`ifdef PUF_MAJORITY_VOTE_EN
   localparam int OW = $clog2(VOTES + 1);
   localparam int VW = $clog2(VOTES);
   logic [OW-1:0] ones_q [R_BITS];
   logic [OW-1:0] ones_d [R_BITS];
   logic [VW-1:0] vote_q, vote_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      chal_d   = chal_q;
      data_d   = data_q;
      stable_d = stable_q;
`ifdef PUF_MAJORITY_VOTE_EN
      vote_d = vote_q;
      for (int b = 0; b < R_BITS; b++) ones_d[b] = ones_q[b];
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               chal_d  = req_challenge;
               cnt_d   = '0;
               state_d = S_PRST;
`ifdef PUF_MAJORITY_VOTE_EN
               vote_d = '0;
               for (int b = 0; b < R_BITS; b++) ones_d[b] = '0;
`endif
            end
         end
         S_PRST: begin
            if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            cnt_d   = '0;
            state_d = S_FIRE;
         end
         S_FIRE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               cnt_d = '0;
`ifdef PUF_MAJORITY_VOTE_EN
               for (int b = 0; b < R_BITS; b++) ones_d[b] = ones_q[b] + OW'(sync2_q[b]);
               if (vote_q == VW'(VOTES - 1)) begin
                  stable_d = 1'b1;
                  for (int b = 0; b < R_BITS; b++) begin
                     data_d[b] = (ones_d[b] > OW'(VOTES / 2));
                     stable_d  = stable_d & ((ones_d[b] == '0) || (ones_d[b] == OW'(VOTES)));
                  end
                  state_d = S_DONE;
               end else begin
                  vote_d  = vote_q + VW'(1);
                  state_d = S_PRST;
               end
`else
               data_d   = sync2_q;
               stable_d = 1'b1;
               state_d  = S_DONE;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output flops are loaded from the next state so every pin changes on the same edge as the FSM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         chal_q       <= '0;
         data_q       <= '0;
         stable_q     <= 1'b0;
         sync1_q      <= '0;
         sync2_q      <= '0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         puf_reset_q  <= 1'b0;
         puf_enable_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         chal_q       <= chal_d;
         data_q       <= data_d;
         stable_q     <= stable_d;
         sync1_q      <= puf_resp;
         sync2_q      <= sync1_q;
         req_ready_q  <= (state_d == S_IDLE);
         rsp_valid_q  <= (state_d == S_DONE);
         busy_q       <= (state_d != S_IDLE);
         puf_reset_q  <= (state_d == S_PRST);
         puf_enable_q <= (state_d == S_FIRE);
      end
   end

`ifdef PUF_MAJORITY_VOTE_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vote_q <= '0;
         for (int b = 0; b < R_BITS; b++) ones_q[b] <= '0;
      end else begin
         vote_q <= vote_d;
         for (int b = 0; b < R_BITS; b++) ones_q[b] <= ones_d[b];
      end
   end
`endif

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = data_q;
   assign rsp_stable    = stable_q;
   assign busy          = busy_q;
   assign puf_reset     = puf_reset_q;
   assign puf_enable    = puf_enable_q;
   assign puf_challenge = chal_q;
   assign dbg_state     = state_q;

endmodule
